// File: rtl/radiant_cal_pulser_if.sv
// Control/status bundle for radiant_cal_pulser.
// master: register bank side (drives mode/period/width/burst/enable/start/stop,
//         observes pulse/busy/done/phase).
// slave:  pulser side (the reverse directions).
interface radiant_cal_pulser_if #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_WIDTH   = 25,
  parameter int unsigned BURST_WIDTH = 8
);

  logic [1:0]             mode_i;
  logic [CNT_WIDTH-1:0]   period_i;
  logic [CNT_WIDTH-1:0]   width_i;
  logic [BURST_WIDTH-1:0] burst_count_i;
  logic [NUM_CH-1:0]      enable_i;
  logic                   start_i;
  logic                   stop_i;
  logic [NUM_CH-1:0]      pulse_o;
  logic                   busy_o;
  logic                   done_o;
  logic [CNT_WIDTH-1:0]   phase_o;

  modport master (
    output mode_i, period_i, width_i, burst_count_i, enable_i, start_i, stop_i,
    input  pulse_o, busy_o, done_o, phase_o
  );

  modport slave (
    input  mode_i, period_i, width_i, burst_count_i, enable_i, start_i, stop_i,
    output pulse_o, busy_o, done_o, phase_o
  );

endinterface

// File: rtl/radiant_cal_pulser.sv
// Multi-channel calibration pulse generator (continuous / burst / single-shot).
// Ports:
//   clk_i  - sysclk
//   rst_i  - asynchronous active-high reset
//   bus    - radiant_cal_pulser_if.slave:
//              mode_i, period_i, width_i, burst_count_i, enable_i,
//              start_i, stop_i (inputs, already synchronised)
//              pulse_o, busy_o, done_o, phase_o (registered outputs)
module radiant_cal_pulser #(
  parameter int unsigned       NUM_CH      = 2,
  parameter int unsigned       CNT_WIDTH   = 25,
  parameter int unsigned       BURST_WIDTH = 8,
  parameter logic [NUM_CH-1:0] POLARITY    = {NUM_CH{1'b0}}
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  radiant_cal_pulser_if.slave    bus
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_mode;
  logic [CNT_WIDTH-1:0]   r_period;
  logic [CNT_WIDTH-1:0]   r_width;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [CNT_WIDTH-1:0]   r_phase;
  logic [BURST_WIDTH-1:0] r_pcount;
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_CH-1:0]      r_pulse;

  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_phase_nxt;
  logic [BURST_WIDTH-1:0] w_pcount_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_latch;
  logic [NUM_CH-1:0]      w_pulse_nxt;

  logic [CNT_WIDTH-1:0]   w_period_eff;
  logic [CNT_WIDTH-1:0]   w_width_eff;
  logic                   w_start_ok;
  logic                   w_phase_last;
  logic                   w_run_end;
  logic                   w_active;

  // Clamp period to >=2 and width to <=P-1 so the output always toggles.
  assign w_period_eff = (bus.period_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : bus.period_i;
  assign w_width_eff  = (bus.width_i >= w_period_eff) ? (w_period_eff - CNT_WIDTH'(1))
                                                      : bus.width_i;

  // Stop has priority over start when both arrive together.
  assign w_start_ok   = bus.start_i & ~bus.stop_i & (bus.mode_i != MODE_OFF);
  assign w_phase_last = (r_phase == (r_period - CNT_WIDTH'(1)));
  assign w_active     = (r_phase < r_width);

  // Natural end of run for the latched mode.
  always_comb begin
    w_run_end = 1'b0;
    case (r_mode)
      MODE_SINGLE: w_run_end = w_phase_last;
      MODE_BURST:  w_run_end = w_phase_last && (r_pcount == (r_burst - BURST_WIDTH'(1)));
      MODE_CONT:   w_run_end = 1'b0;
      default:     w_run_end = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_pcount_nxt = r_pcount;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_latch      = 1'b0;
    w_pulse_nxt  = POLARITY;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          // A zero-length burst completes immediately without entering RUN.
          if ((bus.mode_i == MODE_BURST) && (bus.burst_count_i == '0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_RUN;
            w_busy_nxt   = 1'b1;
            w_phase_nxt  = '0;
            w_pcount_nxt = '0;
            w_latch      = 1'b1;
          end
        end
      end

      ST_RUN: begin
        // Output reflects the phase being left at this edge.
        w_pulse_nxt = ({NUM_CH{w_active}} & bus.enable_i) ^ POLARITY;
        if (bus.stop_i || w_run_end) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_phase_nxt = '0;
        end else if (w_phase_last) begin
          w_phase_nxt  = '0;
          w_pcount_nxt = r_pcount + BURST_WIDTH'(1);
        end else begin
          w_phase_nxt = r_phase + CNT_WIDTH'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_phase_nxt = '0;
      end
    endcase
  end

  // State, counters, shadow registers and outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_OFF;
      r_period <= '0;
      r_width  <= '0;
      r_burst  <= '0;
      r_phase  <= '0;
      r_pcount <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pulse  <= POLARITY;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_pcount <= w_pcount_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_pulse  <= w_pulse_nxt;
      if (w_latch) begin
        r_mode   <= bus.mode_i;
        r_period <= w_period_eff;
        r_width  <= w_width_eff;
        r_burst  <= bus.burst_count_i;
      end
    end
  end

  assign bus.pulse_o = r_pulse;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.phase_o = r_phase;

endmodule
